param_register_file: RTL and testbench



---
 rtl/rf_pkg.sv | 14 +
 rtl/param_register_file_read.sv | 48 ++++
 rtl/param_register_file.sv | 113 +++++++++++
 tb/tb_param_register_file.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the parametrised register file.
// Imported by the top, the read-port slice and the testbench.
package rf_pkg;

    localparam int DEFAULT_DW   = 32;
    localparam int DEFAULT_NREG = 16;
    localparam int PC_STEP      = 4;

    // LSB of port `port` inside a flat bus of `width`-bit lanes
    function automatic int slice_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/param_register_file_read.sv
// One combinational read port: register mux, same-cycle write bypass,
// and busy masking when the bypassed write resolves the hazard.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int NREG    = DEFAULT_NREG,
    parameter int AW      = $clog2(NREG),
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic [AW-1:0]   raddr,
    input  logic [DW-1:0]   regs [NREG],
    input  logic [NREG-1:0] busy,
    input  logic            we0,
    input  logic [AW-1:0]   wa0,
    input  logic [DW-1:0]   wd0,
    input  logic            we1,
    input  logic [AW-1:0]   wa1,
    input  logic [DW-1:0]   wd1,
    output logic [DW-1:0]   rdata,
    output logic            rbusy
);

    logic is_zero;
    logic hit0;
    logic hit1;

    // Select read data: zero register, then port-0 bypass, port-1, storage
    always_comb begin
        is_zero = (R0_ZERO != 0) && (raddr == '0);
        hit0    = (BYPASS != 0) && we0 && (wa0 == raddr);
        hit1    = (BYPASS != 0) && we1 && (wa1 == raddr);
        rdata   = regs[raddr];
        rbusy   = busy[raddr];
        if (is_zero) begin
            rdata = '0;
            rbusy = 1'b0;
        end else if (hit0) begin
            rdata = wd0;
            rbusy = 1'b0;
        end else if (hit1) begin
            rdata = wd1;
            rbusy = 1'b0;
        end
    end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file: two write ports, PC register with external
// load, NRD bypassing read ports and a pending-write scoreboard.
module param_register_file
    import rf_pkg::*;
#(
    parameter int DW      = DEFAULT_DW,
    parameter int NREG    = DEFAULT_NREG,
    parameter int AW      = $clog2(NREG),
    parameter int NRD     = 3,
    parameter int PC_IDX  = NREG - 1,
    parameter int BYPASS  = 1,
    parameter int R0_ZERO = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NRD*AW-1:0] RADDR,
    output logic [NRD*DW-1:0] RDATA,
    output logic [NRD-1:0]    RBUSY,
    input  logic              WE0,
    input  logic [AW-1:0]     WA0,
    input  logic [DW-1:0]     WD0,
    input  logic              WE1,
    input  logic [AW-1:0]     WA1,
    input  logic [DW-1:0]     WD1,
    input  logic              PCLD,
    input  logic [DW-1:0]     PCIN,
    output logic [DW-1:0]     PCOUT,
    input  logic              MARK,
    input  logic [AW-1:0]     MADDR
);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] hit0;
    logic [NREG-1:0] hit1;
    logic [NREG-1:0] mhit;

    // Decode write and mark targets; register 0 is inert when hard-wired
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            hit0[i] = WE0 && (WA0 == AW'(i));
            hit1[i] = WE1 && (WA1 == AW'(i));
            mhit[i] = MARK && (MADDR == AW'(i));
            if ((R0_ZERO != 0) && (i == 0)) begin
                hit0[i] = 1'b0;
                hit1[i] = 1'b0;
                mhit[i] = 1'b0;
            end
        end
    end

    // Next register and busy state: port 0 beats port 1 beats PC load
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
            busy_d[i] = busy_q[i];
            if (hit0[i]) begin
                regs_d[i] = WD0;
            end else if (hit1[i]) begin
                regs_d[i] = WD1;
            end else if ((i == PC_IDX) && PCLD) begin
                regs_d[i] = PCIN;
            end
            if (mhit[i]) begin
                busy_d[i] = 1'b1;
            end else if (hit0[i] || hit1[i]) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    assign PCOUT = regs_q[PC_IDX];

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        rf_read_port #(
            .DW      (DW),
            .NREG    (NREG),
            .AW      (AW),
            .BYPASS  (BYPASS),
            .R0_ZERO (R0_ZERO)
        ) u_rd (
            .raddr (RADDR[slice_lsb(g, AW) +: AW]),
            .regs  (regs_q),
            .busy  (busy_q),
            .we0   (WE0),
            .wa0   (WA0),
            .wd0   (WD0),
            .we1   (WE1),
            .wa1   (WA1),
            .wd1   (WD1),
            .rdata (RDATA[slice_lsb(g, DW) +: DW]),
            .rbusy (RBUSY[g])
        );
    end

endmodule

// File: tb/tb_param_register_file.sv
// Scoreboard bench for param_register_file: three builds (bypass, no-bypass
// with zero register, and a 32x16 four-port variant).
module tb_param_register_file;
    import rf_pkg::*;

    typedef struct {
        int          d;
        int          s;
        int          p;
        logic [31:0] e;
        string       n;
    } chk_t;

    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DC = 2;
    localparam int S_RD = 0;
    localparam int S_BZ = 1;
    localparam int S_PC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] raddr;
    logic        we0, we1, pcld, mark;
    logic [3:0]  wa0, wa1, maddr;
    logic [31:0] wd0, wd1, pcin;
    logic [95:0] rdata_a, rdata_b;
    logic [2:0]  rbusy_a, rbusy_b;
    logic [31:0] pcout_a, pcout_b;

    logic [19:0] raddr_c;
    logic        we0_c, we1_c, pcld_c, mark_c;
    logic [4:0]  wa0_c, wa1_c, maddr_c;
    logic [15:0] wd0_c, wd1_c, pcin_c;
    logic [63:0] rdata_c;
    logic [3:0]  rbusy_c;
    logic [15:0] pcout_c;

    chk_t q[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    param_register_file #(.BYPASS(1), .R0_ZERO(0)) dut_a (
        .CLK(clk), .RST(rst), .RADDR(raddr), .RDATA(rdata_a),
        .RBUSY(rbusy_a), .WE0(we0), .WA0(wa0), .WD0(wd0),
        .WE1(we1), .WA1(wa1), .WD1(wd1), .PCLD(pcld), .PCIN(pcin),
        .PCOUT(pcout_a), .MARK(mark), .MADDR(maddr)
    );

    param_register_file #(.BYPASS(0), .R0_ZERO(1)) dut_b (
        .CLK(clk), .RST(rst), .RADDR(raddr), .RDATA(rdata_b),
        .RBUSY(rbusy_b), .WE0(we0), .WA0(wa0), .WD0(wd0),
        .WE1(we1), .WA1(wa1), .WD1(wd1), .PCLD(pcld), .PCIN(pcin),
        .PCOUT(pcout_b), .MARK(mark), .MADDR(maddr)
    );

    param_register_file #(.DW(16), .NREG(32), .NRD(4), .BYPASS(1)) dut_c (
        .CLK(clk), .RST(rst), .RADDR(raddr_c), .RDATA(rdata_c),
        .RBUSY(rbusy_c), .WE0(we0_c), .WA0(wa0_c), .WD0(wd0_c),
        .WE1(we1_c), .WA1(wa1_c), .WD1(wd1_c), .PCLD(pcld_c),
        .PCIN(pcin_c), .PCOUT(pcout_c), .MARK(mark_c), .MADDR(maddr_c)
    );

    function automatic logic [31:0] actual(int d, int s, int p);
        logic [31:0] v;
        v = '0;
        case (d)
            DA: case (s)
                S_RD: v = rdata_a[p*32 +: 32];
                S_BZ: v = {31'b0, rbusy_a[p]};
                default: v = pcout_a;
            endcase
            DB: case (s)
                S_RD: v = rdata_b[p*32 +: 32];
                S_BZ: v = {31'b0, rbusy_b[p]};
                default: v = pcout_b;
            endcase
            default: case (s)
                S_RD: v = {16'b0, rdata_c[p*16 +: 16]};
                S_BZ: v = {31'b0, rbusy_c[p]};
                default: v = {16'b0, pcout_c};
            endcase
        endcase
        return v;
    endfunction

    task automatic chk(int d, int s, int p, logic [31:0] e, string n);
        chk_t c;
        c.d = d;
        c.s = s;
        c.p = p;
        c.e = e;
        c.n = n;
        q.push_back(c);
    endtask

    task automatic ra(int p, int a);
        raddr[p*4 +: 4] = 4'(a);
    endtask

    task automatic rac(int p, int a);
        raddr_c[p*5 +: 5] = 5'(a);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; pcld = 0; mark = 0;
        we0_c = 0; we1_c = 0; pcld_c = 0; mark_c = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        chk_t c;
        logic [31:0] a;
        while (q.size() > 0) begin
            c = q.pop_front();
            a = actual(c.d, c.s, c.p);
            total++;
            if (a !== c.e) begin
                bad++;
                $display("FAIL %s: got %0h expected %0h", c.n, a, c.e);
            end
        end
    end

    initial begin
        rst = 1;
        idle();
        raddr = '0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        pcin = '0; maddr = '0;
        raddr_c = '0; wa0_c = '0; wa1_c = '0; wd0_c = '0; wd1_c = '0;
        pcin_c = '0; maddr_c = '0;

        step();
        for (int p = 0; p < 3; p++) begin
            chk(DA, S_RD, p, 0, "rst_rd");
            chk(DA, S_BZ, p, 0, "rst_bz");
        end
        chk(DA, S_PC, 0, 0, "rst_pc_a");
        chk(DB, S_PC, 0, 0, "rst_pc_b");
        for (int p = 0; p < 4; p++) chk(DC, S_RD, p, 0, "rst_rd_c");
        chk(DC, S_PC, 0, 0, "rst_pc_c");

        step(); rst = 0;
        we0 = 1; wa0 = 3; wd0 = 32'h55; ra(0, 3);
        chk(DA, S_RD, 0, 32'h55, "byp_r3_a");
        chk(DB, S_RD, 0, 32'h0, "nobyp_r3_b");
        step();
        chk(DA, S_RD, 0, 32'h55, "r3_a");
        chk(DB, S_RD, 0, 32'h55, "r3_b");
        step(); rst = 1;
        chk(DA, S_RD, 0, 0, "async_rst_a");
        chk(DB, S_RD, 0, 0, "async_rst_b");

        step(); rst = 0;
        we0 = 1; wa0 = 5; wd0 = 32'h11;
        we1 = 1; wa1 = 5; wd1 = 32'h22; ra(0, 5);
        chk(DA, S_RD, 0, 32'h11, "coll_byp_a");
        chk(DB, S_RD, 0, 32'h0, "coll_old_b");
        step();
        we1 = 1; wa1 = 6; wd1 = 32'h22; ra(1, 6);
        chk(DA, S_RD, 0, 32'h11, "coll_r5_a");
        chk(DB, S_RD, 0, 32'h11, "coll_r5_b");
        chk(DA, S_RD, 1, 32'h22, "w1_byp_a");
        chk(DB, S_RD, 1, 32'h0, "w1_old_b");
        step();
        chk(DA, S_RD, 1, 32'h22, "w1_r6_a");
        chk(DB, S_RD, 1, 32'h22, "w1_r6_b");

        step();
        pcld = 1; pcin = 32'h40;
        we1 = 1; wa1 = 15; wd1 = 32'h100; ra(2, 15);
        chk(DA, S_RD, 2, 32'h100, "pc_byp_a");
        chk(DB, S_RD, 2, 32'h0, "pc_old_b");
        chk(DA, S_PC, 0, 32'h0, "pc_nocomb");
        step();
        pcld = 1; pcin = 32'h40 + PC_STEP;
        chk(DA, S_PC, 0, 32'h100, "pc_wr_a");
        chk(DB, S_PC, 0, 32'h100, "pc_wr_b");
        chk(DA, S_RD, 2, 32'h100, "pc_rd_a");
        step();
        pcin = 32'h48;
        chk(DA, S_PC, 0, 32'h44, "pc_ld_a");
        chk(DB, S_PC, 0, 32'h44, "pc_ld_b");
        step();
        we0 = 1; wa0 = 15; wd0 = 32'h200;
        we1 = 1; wa1 = 15; wd1 = 32'h300;
        pcld = 1; pcin = 32'h50;
        chk(DA, S_PC, 0, 32'h44, "pc_hold_a");
        chk(DB, S_PC, 0, 32'h44, "pc_hold_b");
        chk(DA, S_RD, 2, 32'h200, "pc_byp0_a");
        chk(DB, S_RD, 2, 32'h44, "pc_rd_b");
        step();
        chk(DA, S_PC, 0, 32'h200, "pc_p0_a");
        chk(DB, S_PC, 0, 32'h200, "pc_p0_b");

        step();
        we0 = 1; wa0 = 7; wd0 = 32'hABCD; ra(0, 7);
        chk(DA, S_RD, 0, 32'hABCD, "r7_byp_a");
        chk(DB, S_RD, 0, 32'h0, "r7_old_b");
        step();
        chk(DA, S_RD, 0, 32'hABCD, "r7_a");
        chk(DB, S_RD, 0, 32'hABCD, "r7_next_b");

        step();
        mark = 1; maddr = 9; ra(1, 9);
        chk(DA, S_BZ, 1, 0, "mark_pre_a");
        chk(DB, S_BZ, 1, 0, "mark_pre_b");
        step();
        chk(DA, S_BZ, 1, 1, "mark_a");
        chk(DB, S_BZ, 1, 1, "mark_b");
        step();
        we1 = 1; wa1 = 9; wd1 = 32'h99;
        chk(DA, S_BZ, 1, 0, "bz_mask_a");
        chk(DB, S_BZ, 1, 1, "bz_nomask_b");
        chk(DA, S_RD, 1, 32'h99, "r9_byp_a");
        step();
        chk(DA, S_BZ, 1, 0, "bz_clr_a");
        chk(DB, S_BZ, 1, 0, "bz_clr_b");
        chk(DB, S_RD, 1, 32'h99, "r9_b");
        step();
        mark = 1; maddr = 9;
        we0 = 1; wa0 = 9; wd0 = 32'h77;
        chk(DA, S_BZ, 1, 0, "mkwr_mask_a");
        chk(DB, S_BZ, 1, 0, "mkwr_pre_b");
        step();
        chk(DA, S_BZ, 1, 1, "mark_wins_a");
        chk(DB, S_BZ, 1, 1, "mark_wins_b");
        chk(DA, S_RD, 1, 32'h77, "r9_77_a");
        step();
        we0 = 1; wa0 = 9; wd0 = 32'h1;
        we1 = 1; wa1 = 9; wd1 = 32'h2;
        chk(DB, S_BZ, 1, 1, "coll_bz_b");
        step();
        chk(DA, S_BZ, 1, 0, "coll_clr_a");
        chk(DB, S_BZ, 1, 0, "coll_clr_b");
        chk(DB, S_RD, 1, 32'h1, "coll_r9_b");

        step();
        we0 = 1; wa0 = 0; wd0 = 32'hFFFF;
        mark = 1; maddr = 0; ra(0, 0);
        chk(DA, S_RD, 0, 32'hFFFF, "r0_byp_a");
        chk(DB, S_RD, 0, 32'h0, "r0_zero_b");
        chk(DB, S_BZ, 0, 0, "r0_bz_pre_b");
        step();
        chk(DA, S_RD, 0, 32'hFFFF, "r0_a");
        chk(DB, S_RD, 0, 32'h0, "r0_hold_b");
        chk(DA, S_BZ, 0, 1, "r0_bz_a");
        chk(DB, S_BZ, 0, 0, "r0_bz_b");

        step();
        we0_c = 1; wa0_c = 31; wd0_c = 16'h1234;
        we1_c = 1; wa1_c = 4; wd1_c = 16'hBEEF;
        pcld_c = 1; pcin_c = 16'h10;
        rac(0, 31); rac(1, 4); rac(2, 0); rac(3, 2);
        chk(DC, S_RD, 0, 32'h1234, "c_byp0");
        chk(DC, S_RD, 1, 32'hBEEF, "c_byp1");
        chk(DC, S_RD, 2, 32'h0, "c_r0");
        chk(DC, S_PC, 0, 32'h0, "c_pc0");
        step();
        we0_c = 1; wa0_c = 2; wd0_c = 16'h0202;
        we1_c = 1; wa1_c = 30; wd1_c = 16'h3030;
        rac(0, 31); rac(1, 4); rac(2, 2); rac(3, 30);
        chk(DC, S_RD, 0, 32'h1234, "c_rd0");
        chk(DC, S_RD, 1, 32'hBEEF, "c_rd1");
        chk(DC, S_RD, 2, 32'h0202, "c_rd2");
        chk(DC, S_RD, 3, 32'h3030, "c_rd3");
        chk(DC, S_PC, 0, 32'h1234, "c_pc_wr");
        step();
        pcld_c = 1; pcin_c = 16'h10;
        rac(0, 30); rac(1, 2); rac(2, 31); rac(3, 4);
        chk(DC, S_RD, 0, 32'h3030, "c_x0");
        chk(DC, S_RD, 1, 32'h0202, "c_x1");
        chk(DC, S_RD, 2, 32'h1234, "c_x2");
        chk(DC, S_RD, 3, 32'hBEEF, "c_x3");
        chk(DC, S_PC, 0, 32'h1234, "c_pc_hold");
        step();
        chk(DC, S_PC, 0, 32'h10, "c_pc_ld");

        step();
        step();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
